// File: rtl/char_code_scroller_if.sv
// char_code_scroller_if: message-load, run control and display-side signals of the scroller.
// Latency: pure wiring, no storage.
// Backpressure: none carried; the scroller drops writes it cannot accept.
interface char_code_scroller_if;
  logic       clear;
  logic       wr_en;
  logic [4:0] wr_data;
  logic       run;
  logic [4:0] code_out;
  logic [3:0] dig_sel;
  logic       step_pulse;
  logic       full;

  // master drives the message and run level, slave is the scroller itself
  modport master (
    output clear, wr_en, wr_data, run,
    input  code_out, dig_sel, step_pulse, full
  );

  modport slave (
    input  clear, wr_en, wr_data, run,
    output code_out, dig_sel, step_pulse, full
  );
endinterface

// File: rtl/char_code_scroller.sv
// char_code_scroller: holds a 5-bit char message and scrolls a 4-digit multiplexed window (SCROLL_GAP_EN adds 4 blanks).
// Latency: code_out/dig_sel registered together; a state/pos/mem change shows within one cycle of the current slot.
// Backpressure: none; writes outside IDLE or while full are silently dropped.
module char_code_scroller #(
  parameter int         DEPTH      = 16,
  parameter int         STEP_DIV   = 50_000_000,
  parameter int         MUX_DIV    = 50_000,
  parameter logic [4:0] BLANK_CODE = 5'h1F
) (
  input logic               clk,
  input logic               rst,
  char_code_scroller_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // wide enough for pos + 3 with or without the blank gap
  localparam int LW = $clog2(DEPTH + 8) + 1;
  localparam int SW = $clog2(STEP_DIV);
  localparam int MW = $clog2(MUX_DIV + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    mem [DEPTH];
  logic [CW-1:0] count_q;
  logic [LW-1:0] pos_q;
  logic [SW-1:0] step_cnt_q;
  logic [MW-1:0] mux_cnt_q;
  logic [1:0]    slot_q;
  logic [3:0]    dig_sel_q;
  logic [4:0]    code_out_q;
  logic          step_pulse_q;
  logic          full_q;

  logic          wr_ok;
  logic [CW-1:0] count_inc;
  logic [LW-1:0] vlen;
  logic [LW-1:0] pos_inc;
  logic          step_done;
  logic          mux_wrap;
  logic [1:0]    slot_d;
  logic [LW-1:0] idx;
  logic [4:0]    digit_code;

  // control decode: write acceptance, virtual length, step and refresh boundaries
  always_comb begin
    wr_ok     = bus.wr_en && (state_q == IDLE) && (count_q != CW'(DEPTH));
    count_inc = count_q + CW'(wr_ok);
`ifdef SCROLL_GAP_EN
    vlen      = LW'(count_q) + LW'(4);
`else
    vlen      = LW'(count_q);
`endif
    pos_inc   = pos_q + LW'(1);
    step_done = (state_q == RUN) && (step_cnt_q == SW'(STEP_DIV - 1));
    mux_wrap  = (mux_cnt_q == MW'(MUX_DIV - 1));
    slot_d    = mux_wrap ? slot_q + 2'd1 : slot_q;
  end

  // next state; the IDLE exit looks at the count including a same-cycle write
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.run && (count_inc != '0)) state_d = RUN;
        RUN:     if (!bus.run) state_d = PAUSE;
        PAUSE:   if (bus.run) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // message storage; only the IDLE append path writes it
  always_ff @(posedge clk) begin
    if (!rst && !bus.clear && wr_ok) mem[count_q[AW-1:0]] <= bus.wr_data;
  end

  // count, scroll offset, step divider and step pulse
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      count_q      <= '0;
      pos_q        <= '0;
      step_cnt_q   <= '0;
      step_pulse_q <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      step_pulse_q <= 1'b0;
      count_q      <= count_inc;
      full_q       <= (count_inc == CW'(DEPTH));
      if (state_q == IDLE) begin
        pos_q      <= '0;
        step_cnt_q <= '0;
      end else if (state_q == RUN) begin
        if (step_done) begin
          step_cnt_q   <= '0;
          pos_q        <= (pos_inc == vlen) ? '0 : pos_inc;
          step_pulse_q <= 1'b1;
        end else begin
          step_cnt_q <= step_cnt_q + SW'(1);
        end
      end
    end
  end

  // message index for the digit about to be shown; pos + i stays below L + 3,
  // so three conditional subtractions give an exact modulo even for L < 4
  always_comb begin
    idx = pos_q + LW'(slot_d);
    for (int k = 0; k < 3; k++) begin
      if (idx >= vlen) idx = idx - vlen;
    end
    digit_code = BLANK_CODE;
    if (idx < LW'(count_q)) digit_code = mem[idx[AW-1:0]];
  end

  // free-running refresh: digit select and its code are loaded on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_cnt_q  <= '0;
      slot_q     <= 2'd0;
      dig_sel_q  <= 4'b0001;
      code_out_q <= BLANK_CODE;
    end else begin
      mux_cnt_q  <= mux_wrap ? '0 : mux_cnt_q + MW'(1);
      slot_q     <= slot_d;
      dig_sel_q  <= 4'b0001 << slot_d;
      code_out_q <= (bus.clear || (state_q == IDLE)) ? BLANK_CODE : digit_code;
    end
  end

  assign bus.code_out   = code_out_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.full       = full_q;

endmodule

// File: tb/tb_char_code_scroller.sv
// tb_char_code_scroller: random and directed message/run/clear traffic against a queue-based scroll model.
// Latency: expectations are queued per clock edge and popped by a negedge monitor.
// Backpressure: step events are matched by cycle stamp from their own queue.
module tb_char_code_scroller;
  localparam int         DEPTH    = 8;
  localparam int         STEP_DIV = 8;
  localparam int         MUX_DIV  = 2;
  localparam logic [4:0] BLANK    = 5'h1F;
`ifdef SCROLL_GAP_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  char_code_scroller_if bus ();

  char_code_scroller #(
    .DEPTH(DEPTH), .STEP_DIV(STEP_DIV), .MUX_DIV(MUX_DIV), .BLANK_CODE(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit rst_now;
    bit clr_now;
    bit stable;
    int slot;
    int code;
    bit full;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   step_q[$];

  // reference model: message as a queue, mode 0 idle / 1 run / 2 pause
  int msg[$];
  int mode = 0;
  int pos = 0;
  int elapsed = 0;
  int mph = 0;
  int slot = 0;
  bit run_lvl;
  int rr, cc, ww;

  function automatic void check(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic int win_code(int i);
    int l;
    int j;
    if (mode == 0) return BLANK;
    l = msg.size() + GAP;
    j = (pos + i) % l;
    return (j < msg.size()) ? msg[j] : BLANK;
  endfunction

  task automatic model_edge(bit r, bit c, bit w, int wd, bit rn);
    exp_t e;
    int sp = pos;
    int ss = msg.size();
    int sm = mode;
    if (r) begin
      msg.delete();
      mode = 0; pos = 0; elapsed = 0; mph = 0; slot = 0;
    end else begin
      mph++;
      if (mph == MUX_DIV) begin
        mph  = 0;
        slot = (slot + 1) % 4;
      end
      if (c) begin
        msg.delete();
        mode = 0; pos = 0; elapsed = 0;
      end else begin
        if (mode == 0 && w && msg.size() < DEPTH) msg.push_back(wd);
        if (mode == 1) begin
          elapsed++;
          if (elapsed == STEP_DIV) begin
            elapsed = 0;
            pos = (pos + 1) % (msg.size() + GAP);
            step_q.push_back(cyc);
          end
        end
        case (mode)
          0: if (rn && msg.size() > 0) begin mode = 1; pos = 0; elapsed = 0; end
          1: if (!rn) mode = 2;
          default: if (rn) mode = 1;
        endcase
      end
    end
    e.rst_now = r;
    e.clr_now = c && !r;
    e.stable  = (sp == pos) && (ss == msg.size()) && (sm == mode);
    e.slot    = slot;
    e.code    = win_code(slot);
    e.full    = (msg.size() == DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic cycle(bit r, bit c, bit w, int wd, bit rn);
    rst         = r;
    bus.clear   = c;
    bus.wr_en   = w;
    bus.wr_data = wd[4:0];
    bus.run     = rn;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(r, c, w, wd, rn);
  endtask

  // monitor: pops one expectation per edge, matches step pulses by cycle stamp
  exp_t m;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        check("dig_sel", int'(bus.dig_sel), 1 << m.slot);
        check("full", int'(bus.full), int'(m.full));
        if (m.rst_now || m.clr_now || m.stable)
          check(m.rst_now ? "code_out_reset" : (m.clr_now ? "code_out_clear" : "code_out"),
                int'(bus.code_out), m.code);
      end
      if (bus.step_pulse === 1'b1) begin
        if (step_q.size() == 0) check("step_pulse_spurious", 1, 0);
        else check("step_pulse_cycle", cyc, step_q.pop_front());
      end else if (step_q.size() > 0 && step_q[0] <= cyc) begin
        check("step_pulse_missing", int'(bus.step_pulse), 1);
        void'(step_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; bus.clear = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 5'd0; bus.run = 1'b0;
    // reset and release
    repeat (3) cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0);
    // fill past DEPTH; the ninth and tenth writes must be dropped
    for (int k = 0; k < 10; k++) cycle(0, 0, 1, $urandom_range(0, 30), 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    // scroll the full message through several wraps
    repeat (90) cycle(0, 0, 0, 0, 1);
    // pause a few cycles after a step, try a write while paused, resume
    repeat (3) cycle(0, 0, 0, 0, 1);
    repeat (10) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 7, 0);
    repeat (10) cycle(0, 0, 0, 0, 0);
    repeat (40) cycle(0, 0, 0, 0, 1);
    // clear wins over a same-cycle write and run
    cycle(0, 1, 1, 7, 1);
    repeat (4) cycle(0, 0, 0, 0, 0);
    // short messages: window modulo with L below 4, then a five-char message
    for (int len = 1; len <= 5; len++) begin
      for (int k = 0; k < len; k++) cycle(0, 0, 1, $urandom_range(0, 30), 0);
      repeat (2) cycle(0, 0, 0, 0, 0);
      repeat (30 + 8 * len) cycle(0, 0, 0, 0, 1);
      repeat ($urandom_range(1, 6)) cycle(0, 0, 0, 0, 0);
      repeat (20) cycle(0, 0, 0, 0, 1);
      cycle(0, 1, 0, 0, 0);
      repeat (2) cycle(0, 0, 0, 0, 0);
    end
    // random traffic
    run_lvl = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      rr = ($urandom_range(0, 499) == 0) ? 1 : 0;
      cc = ($urandom_range(0, 63) == 0) ? 1 : 0;
      ww = ($urandom_range(0, 2) == 0) ? 1 : 0;
      if ($urandom_range(0, 39) == 0) run_lvl = ~run_lvl;
      cycle(rr[0], cc[0], ww[0], $urandom_range(0, 31), run_lvl);
    end
    // mid-scroll reset
    repeat (3) cycle(0, 0, 1, 5, 0);
    repeat (12) cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("exp_queue_drained", exp_q.size(), 0);
    check("step_queue_drained", step_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/char_code_scroller.md
# char_code_scroller

Upstream feeder for the 5-bit ASCII character segment decoder. Stores a short message of 5-bit character codes, scrolls it across a 4-digit multiplexed display, and presents one digit's code per refresh slot with a one-hot digit select. The decoder turns `code_out` into segments a..g, and `dig_sel` drives the digit enables.

## Interface
- `DEPTH`, 16: message buffer entries; power of two, at least 4.
- `STEP_DIV`, 50_000_000: clock cycles per scroll step; at least 2.
- `MUX_DIV`, 50_000: clock cycles per digit refresh slot; at least 1.
- `BLANK_CODE`, 5'h1F: code driven for blank positions.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  empty the buffer, return to IDLE.
- `wr_en`  in  1  append `wr_data` to the message.
- `wr_data`  in  5  character code {A,B,C,D,E}, A = bit 4.
- `run`  in  1  level: 1 = scroll, 0 = pause/stop.
- `code_out`  out  5  code for the digit currently selected, to decoder A..E (bit 4 = A).
- `dig_sel`  out  4  one-hot, active-high digit enable; bit 0 is the leftmost digit.
- `step_pulse`  out  1  one-cycle pulse on each scroll advance.
- `full`  out  1  buffer holds DEPTH codes.

## Operation
- Storage: `mem[0..DEPTH-1]`, `count` (0..DEPTH), `pos` (scroll offset).
- States:
  - IDLE: nothing scrolls; `code_out` = BLANK_CODE.
  - RUN: the window scrolls.
  - PAUSE: the window is frozen and still multiplexed.
- Transitions:
  - IDLE→RUN when `run`=1 and count>0. Count is the post-write value if a write happens in the same cycle.
  - RUN→PAUSE when `run`=0.
  - PAUSE→RUN when `run`=1.
  - Any state→IDLE on `clear`. This sets count=0 and pos=0 and zeroes the step counter.
- Writes are accepted only in IDLE with `full`=0: `mem[count]` = wr_data, count++. Writes are silently ignored in RUN or PAUSE, or when full.
- Priority: `rst` > `clear` > `wr_en` / `run`.
- Virtual length: L = count (plus 4 with gap, see Configuration).
- Digit i (0..3) shows index j = (pos+i) mod L.
  - If j ≥ count, the digit shows BLANK_CODE; otherwise it shows `mem[j]`.
  - The modulo must be exact even when L < 4. Example: count=1, no gap: every digit shows mem[0].
- Scroll: in RUN, after STEP_DIV cycles pos ← (pos+1) mod L, and `step_pulse` is high for that cycle. pos wraps from L-1 to 0.
- Entering RUN from IDLE: the step counter starts at 0 and pos=0.
- PAUSE holds both the step counter and pos. Resuming continues the remaining count.

## Timing
- Reset values:
  - state IDLE, count=0, pos=0, counters 0.
  - `dig_sel`=4'b0001, `code_out`=BLANK_CODE, `step_pulse`=0, `full`=0.
- Refresh: a free-running refresh counter advances dig_sel 0001→0010→0100→1000→0001 every MUX_DIV cycles in all states.
- `code_out` and `dig_sel` are registered and change on the same edge; they never mismatch.
- Latency: a pos, state or mem change is visible on `code_out` at the next slot boundary, or within 1 cycle if it occurs mid-slot.
- `step_pulse`: asserted in the cycle pos changes; first pulse at cycle STEP_DIV after entering RUN.
- `full`: registered, tracks count==DEPTH; drops on the cycle after `clear`.
- Reset or clear mid-scroll: the next cycle's outputs are the reset values, except that `dig_sel` keeps rotating after `clear`.

## Configuration
- `SCROLL_GAP_EN` defined:
  - L = count+4, so four blank positions separate repetitions of the message.
  - A message of 4 or more chars fully scrolls off before reappearing.
- `SCROLL_GAP_EN` undefined:
  - L = count; the message wraps directly (last char followed by the first).
  - No gap logic is present.

## Test plan
Use DEPTH=8, STEP_DIV=8, MUX_DIV=2 and BLANK_CODE=5'h1F for all scenarios.
- Reset check: hold `rst` 3 cycles → dig_sel=0001, code_out=1F, full=0, step_pulse=0; dig_sel reaches 0010 two cycles after release.
- Fill and full: write codes 1..9 in IDLE → count=8, full=1 after the 8th write; the 9th write is ignored and mem[7]=8.
- Scroll without gap: load 1,2,3,4,5, assert `run` → first window 1,2,3,4. After step_pulse at cycle 8 the window is 2,3,4,5; after 5 steps pos wraps to 0. Window at pos=3 is 4,5,1,2.
- Scroll with gap (`SCROLL_GAP_EN`): load 1,2,3, run → windows are 1,2,3,1F then 2,3,1F,1F, …; pos wraps after 7 steps back to 1,2,3,1F.
- Pause and resume: deassert `run` 3 cycles after a step → pos frozen and no step_pulse for 20 cycles. Reassert → next pulse after the remaining 5 cycles. A `wr_en` during PAUSE is ignored.
- Clear priority: assert `clear`, `wr_en` (data 7) and `run` in the same cycle while running → IDLE, count=0, code_out=1F, no write.
